// File: rtl/addr_decoder_pkg.sv
// Shared constants for the vector-core CPU bus decoder: port indices, region
// encoding and the address-to-region decode function.
package addr_decoder_pkg;

    localparam int NPORT = 5;

    localparam int BRAM_PROG_RAM = 0;
    localparam int BRAM_PROG_ROM = 1;
    localparam int BRAM_VECTOR   = 2;
    localparam int BRAM_MATH     = 3;
    localparam int BRAM_POKEY    = 4;

    typedef enum logic [3:0] {
        R_RAM, R_ROM, R_VEC, R_MATH, R_POKEY,
        R_IN0, R_DSW0, R_DSW1, R_BTN, R_NONE
    } region_e;

    localparam logic [14:0] A_RAM_END    = 15'h07FF;
    localparam logic [14:0] A_IN0        = 15'h0800;
    localparam logic [14:0] A_DSW0       = 15'h0A00;
    localparam logic [14:0] A_DSW1       = 15'h0C00;
    localparam logic [14:0] A_VGGO       = 15'h1200;
    localparam logic [14:0] A_VGRST      = 15'h1600;
    localparam logic [14:0] A_MATH_STAT  = 15'h1800;
    localparam logic [14:0] A_RB_BTN     = 15'h1802;
    localparam logic [14:0] A_RB_MATH_LO = 15'h1804;
    localparam logic [14:0] A_RB_MATH_HI = 15'h1806;
    localparam logic [14:0] A_BZ_MATH_LO = 15'h1810;
    localparam logic [14:0] A_BZ_MATH_HI = 15'h1818;
    localparam logic [14:0] A_MATH_WR_LO = 15'h1860;
    localparam logic [14:0] A_MATH_WR_HI = 15'h187F;
    localparam logic [14:0] A_VEC_LO     = 15'h2000;
    localparam logic [14:0] A_VEC_HI     = 15'h3FFF;
    localparam logic [14:0] A_ROM_LO     = 15'h4000;

    // POKEY occupies 1820-182F on Battlezone and 1810-181F on Red Baron.
    function automatic logic is_pokey(input logic [14:0] a, input logic mod_rb);
        return mod_rb ? (a[14:4] == 11'h181) : (a[14:4] == 11'h182);
    endfunction

    // Math box reads and writes live at different addresses, so the
    // direction is part of the decode.
    function automatic region_e decode_region(input logic [14:0] a,
                                              input logic        mod_rb,
                                              input logic        is_write);
        region_e r;
        r = R_NONE;
        if (a <= A_RAM_END) begin
            r = R_RAM;
        end else if (a >= A_ROM_LO) begin
            r = R_ROM;
        end else if (a >= A_VEC_LO && a <= A_VEC_HI) begin
            r = R_VEC;
        end else if (is_write) begin
            if (a >= A_MATH_WR_LO && a <= A_MATH_WR_HI) r = R_MATH;
            else if (is_pokey(a, mod_rb))                r = R_POKEY;
        end else begin
            if      (a == A_IN0)                                        r = R_IN0;
            else if (a == A_DSW0)                                       r = R_DSW0;
            else if (a == A_DSW1)                                       r = R_DSW1;
            else if (a == A_MATH_STAT)                                  r = R_MATH;
            else if (mod_rb && a == A_RB_BTN)                           r = R_BTN;
            else if (mod_rb && (a == A_RB_MATH_LO || a == A_RB_MATH_HI)) r = R_MATH;
            else if (!mod_rb && (a == A_BZ_MATH_LO || a == A_BZ_MATH_HI)) r = R_MATH;
            else if (is_pokey(a, mod_rb))                               r = R_POKEY;
        end
        return r;
    endfunction

endpackage

// File: rtl/addr_decoder_if.sv
// CPU-side bus and BRAM-port bundle between the system top (master) and the
// address decoder (slave).
interface addr_decoder_if;
    import addr_decoder_pkg::*;

    logic                        clk_en;
    logic [15:0]                 addr;
    logic [7:0]                  dataFromCore;
    logic                        we;
    logic [NPORT-1:0][7:0]       dataFromBram;
    logic [7:0]                  dataToCore;
    logic [NPORT-1:0][15:0]      addrToBram;
    logic [NPORT-1:0][7:0]       dataToBram;
    logic [NPORT-1:0]            weEnBram;

    modport master (
        output clk_en, addr, dataFromCore, we, dataFromBram,
        input  dataToCore, addrToBram, dataToBram, weEnBram
    );

    modport slave (
        input  clk_en, addr, dataFromCore, we, dataFromBram,
        output dataToCore, addrToBram, dataToBram, weEnBram
    );

endinterface

// File: rtl/addr_decoder.sv
// 6502 bus decoder for the Battlezone/Red Baron vector core: memory port
// selection, input-port reads and vector generator strobes.
module addr_decoder
    import addr_decoder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    addr_decoder_if.slave        bus,
    input  logic                 halt,
    input  logic                 clk_3KHz,
    input  logic                 self_test,
    input  logic [7:0]           DSW0,
    input  logic [7:0]           DSW1,
    input  logic [7:0]           REDBARONBUTTONS,
    input  logic                 coin,
    input  logic                 mod_redbaron,
    output logic                 vggo,
    output logic                 vgrst
);

    region_e    rd_region;
    region_e    wr_region;
    region_e    sel_q, sel_d;
    logic [7:0] port_q, port_d;
    logic [7:0] in0;

    assign in0 = {clk_3KHz, halt, 1'b1, ~self_test, 1'b1, 1'b1, 1'b1, ~coin};

    assign rd_region = decode_region(bus.addr[14:0], mod_redbaron, 1'b0);
    assign wr_region = decode_region(bus.addr[14:0], mod_redbaron, 1'b1);

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        bus.weEnBram = '0;
        for (int i = 0; i < NPORT; i++) begin
            bus.addrToBram[i] = bus.addr;
            bus.dataToBram[i] = bus.dataFromCore;
        end
        case (wr_region)
            R_RAM:   bus.weEnBram[BRAM_PROG_RAM] = bus.we;
            R_ROM:   bus.weEnBram[BRAM_PROG_ROM] = bus.we;
            R_VEC:   bus.weEnBram[BRAM_VECTOR]   = bus.we;
            R_MATH:  bus.weEnBram[BRAM_MATH]     = bus.we;
            R_POKEY: bus.weEnBram[BRAM_POKEY]    = bus.we;
            default: ;
        endcase
    end

    // Only a CPU read cycle moves the select; writes and idle clocks hold it.
    always_comb begin
        sel_d  = sel_q;
        port_d = port_q;
        if (bus.clk_en && !bus.we) begin
            sel_d = rd_region;
            case (rd_region)
                R_IN0:   port_d = in0;
                R_DSW0:  port_d = DSW0;
                R_DSW1:  port_d = DSW1;
                R_BTN:   port_d = REDBARONBUTTONS;
                default: port_d = 8'h00;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= R_NONE;
            port_q <= 8'h00;
        end else begin
            sel_q  <= sel_d;
            port_q <= port_d;
        end
    end

    always_comb begin
        bus.dataToCore = 8'h00;
        case (sel_q)
            R_RAM:   bus.dataToCore = bus.dataFromBram[BRAM_PROG_RAM];
            R_ROM:   bus.dataToCore = bus.dataFromBram[BRAM_PROG_ROM];
            R_VEC:   bus.dataToCore = bus.dataFromBram[BRAM_VECTOR];
            R_MATH:  bus.dataToCore = bus.dataFromBram[BRAM_MATH];
            R_POKEY: bus.dataToCore = bus.dataFromBram[BRAM_POKEY];
            R_IN0, R_DSW0, R_DSW1, R_BTN: bus.dataToCore = port_q;
            default: bus.dataToCore = 8'h00;
        endcase
    end

    assign vggo  = bus.we & bus.clk_en & ~rst & (bus.addr[14:0] == A_VGGO);
    assign vgrst = bus.we & bus.clk_en & ~rst & (bus.addr[14:0] == A_VGRST);

endmodule

// File: tb/tb_addr_decoder.sv
// Directed self-checking bench for addr_decoder: write enables, strobes,
// input-port reads, region reads per map variant and reset behaviour.
module tb_addr_decoder;
    import addr_decoder_pkg::*;

    logic       clk;
    logic       rst;
    logic       halt, clk_3KHz, self_test, coin, mod_redbaron;
    logic [7:0] DSW0, DSW1, REDBARONBUTTONS;
    logic       vggo, vgrst;
    int         n_pass;
    int         n_total;

    addr_decoder_if bus ();

    addr_decoder dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .halt            (halt),
        .clk_3KHz        (clk_3KHz),
        .self_test       (self_test),
        .DSW0            (DSW0),
        .DSW1            (DSW1),
        .REDBARONBUTTONS (REDBARONBUTTONS),
        .coin            (coin),
        .mod_redbaron    (mod_redbaron),
        .vggo            (vggo),
        .vgrst           (vgrst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus.clk_en = 1'b0;
        bus.we     = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, input logic m);
        mod_redbaron = m;
        bus.addr     = a;
        bus.we       = 1'b0;
        bus.clk_en   = 1'b1;
        tick();
        idle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.addr = 16'h0A00; bus.we = 1'b0; bus.clk_en = 1'b1;
        tick(); tick();
        n_total++;
        if (bus.dataToCore !== 8'h00) $display("FAIL reset_data: got %h expected 00", bus.dataToCore);
        else n_pass++;
        bus.addr = 16'h1200; bus.we = 1'b1; bus.clk_en = 1'b1;
        #1;
        n_total++;
        if ({vggo, vgrst} !== 2'b00) $display("FAIL reset_strobe: got %b expected 00", {vggo, vgrst});
        else n_pass++;
        tick();
        rst = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_ram_write();
        bus.addr = 16'h0123; bus.dataFromCore = 8'h5A; bus.we = 1'b1; bus.clk_en = 1'b1;
        #1;
        n_total++;
        if (bus.weEnBram !== 5'b00001) $display("FAIL ram_we: got %b expected 00001", bus.weEnBram);
        else n_pass++;
        for (int i = 0; i < NPORT; i++) begin
            n_total++;
            if (bus.addrToBram[i] !== 16'h0123 || bus.dataToBram[i] !== 8'h5A)
                $display("FAIL ram_bus[%0d]: got %h/%h expected 0123/5a", i, bus.addrToBram[i], bus.dataToBram[i]);
            else n_pass++;
        end
        n_total++;
        if ({vggo, vgrst} !== 2'b00) $display("FAIL ram_strobe: got %b expected 00", {vggo, vgrst});
        else n_pass++;
        tick();
        idle();
    endtask

    typedef struct { logic [15:0] a; logic m; logic [4:0] e; } wr_vec_t;

    task automatic test_bram_writes();
        wr_vec_t tab [9];
        tab = '{'{16'h2400, 1'b0, 5'b00100}, '{16'h1860, 1'b0, 5'b01000},
                '{16'h187F, 1'b0, 5'b01000}, '{16'h1820, 1'b0, 5'b10000},
                '{16'h1815, 1'b1, 5'b10000}, '{16'h1815, 1'b0, 5'b00000},
                '{16'h1840, 1'b0, 5'b00000}, '{16'h4000, 1'b0, 5'b00010},
                '{16'h1800, 1'b0, 5'b00000}};
        for (int i = 0; i < 9; i++) begin
            mod_redbaron = tab[i].m;
            bus.addr = tab[i].a; bus.dataFromCore = 8'hC0; bus.we = 1'b1; bus.clk_en = 1'b1;
            #1;
            n_total++;
            if (bus.weEnBram !== tab[i].e || {vggo, vgrst} !== 2'b00)
                $display("FAIL wr_%h_m%0d: got we=%b strobes=%b expected we=%b strobes=00",
                         tab[i].a, tab[i].m, bus.weEnBram, {vggo, vgrst}, tab[i].e);
            else n_pass++;
            tick();
        end
        idle();
        mod_redbaron = 1'b0;
    endtask

    task automatic test_strobes();
        bus.addr = 16'h1200; bus.we = 1'b1; bus.clk_en = 1'b1;
        #1;
        n_total++;
        if ({vggo, vgrst, bus.weEnBram} !== 7'b10_00000)
            $display("FAIL vggo_pulse: got %b expected 1000000", {vggo, vgrst, bus.weEnBram});
        else n_pass++;
        tick();
        bus.clk_en = 1'b0;
        #1;
        n_total++;
        if (vggo !== 1'b0) $display("FAIL vggo_one_clk: got %b expected 0", vggo);
        else n_pass++;
        tick();
        n_total++;
        if (vggo !== 1'b0) $display("FAIL vggo_no_clk_en: got %b expected 0", vggo);
        else n_pass++;
        bus.addr = 16'h1600; bus.clk_en = 1'b1;
        #1;
        n_total++;
        if ({vggo, vgrst} !== 2'b01) $display("FAIL vgrst_pulse: got %b expected 01", {vggo, vgrst});
        else n_pass++;
        tick();
        idle();
        #1;
        n_total++;
        if (vgrst !== 1'b0) $display("FAIL vgrst_one_clk: got %b expected 0", vgrst);
        else n_pass++;
    endtask

    task automatic test_in0_read();
        halt = 1'b1; clk_3KHz = 1'b0; coin = 1'b1; self_test = 1'b0;
        bus.addr = 16'h0800; bus.we = 1'b0; bus.clk_en = 1'b1;
        #1;
        n_total++;
        if (bus.weEnBram !== 5'b00000) $display("FAIL in0_no_we: got %b expected 00000", bus.weEnBram);
        else n_pass++;
        tick();
        idle();
        halt = 1'b0;
        #1;
        n_total++;
        if (bus.dataToCore !== 8'h7E) $display("FAIL in0_a: got %h expected 7e", bus.dataToCore);
        else n_pass++;
        halt = 1'b0; clk_3KHz = 1'b1; coin = 1'b0; self_test = 1'b1;
        do_read(16'h0800, 1'b0);
        n_total++;
        if (bus.dataToCore !== 8'hAF) $display("FAIL in0_b: got %h expected af", bus.dataToCore);
        else n_pass++;
    endtask

    task automatic test_rom_read();
        bus.addr = 16'h5000; bus.we = 1'b0; bus.clk_en = 1'b1;
        #1;
        n_total++;
        if (bus.weEnBram !== 5'b00000) $display("FAIL rom_no_we: got %b expected 00000", bus.weEnBram);
        else n_pass++;
        tick();
        idle();
        #1;
        n_total++;
        if (bus.dataToCore !== 8'hA9) $display("FAIL rom_read: got %h expected a9", bus.dataToCore);
        else n_pass++;
        bus.addr = 16'h0A00;
        tick();
        n_total++;
        if (bus.dataToCore !== 8'hA9) $display("FAIL rom_hold: got %h expected a9", bus.dataToCore);
        else n_pass++;
    endtask

    typedef struct { logic [15:0] a; logic m; logic [7:0] e; } rd_vec_t;

    task automatic test_region_reads();
        rd_vec_t tab [13];
        tab = '{'{16'h0A00, 1'b0, 8'h12}, '{16'h0C00, 1'b0, 8'h34},
                '{16'h1802, 1'b1, 8'hC3}, '{16'h1812, 1'b1, 8'h44},
                '{16'h1824, 1'b0, 8'h44}, '{16'h1810, 1'b0, 8'h33},
                '{16'h1818, 1'b0, 8'h33}, '{16'h1806, 1'b1, 8'h33},
                '{16'h1800, 1'b0, 8'h33}, '{16'h1000, 1'b0, 8'h00},
                '{16'h1802, 1'b0, 8'h00}, '{16'h07FF, 1'b0, 8'h11},
                '{16'h3000, 1'b0, 8'h22}};
        for (int i = 0; i < 13; i++) begin
            do_read(tab[i].a, tab[i].m);
            n_total++;
            if (bus.dataToCore !== tab[i].e)
                $display("FAIL rd_%h_m%0d: got %h expected %h", tab[i].a, tab[i].m, bus.dataToCore, tab[i].e);
            else n_pass++;
        end
        mod_redbaron = 1'b0;
    endtask

    task automatic test_reset_pending();
        do_read(16'h5000, 1'b0);
        bus.addr = 16'h0A00; bus.we = 1'b0; bus.clk_en = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        #1;
        n_total++;
        if (bus.dataToCore !== 8'h00 || {vggo, vgrst} !== 2'b00)
            $display("FAIL reset_pending: got %h/%b expected 00/00", bus.dataToCore, {vggo, vgrst});
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        halt = 1'b0; clk_3KHz = 1'b0; self_test = 1'b0; coin = 1'b0; mod_redbaron = 1'b0;
        DSW0 = 8'h12; DSW1 = 8'h34; REDBARONBUTTONS = 8'hC3;
        bus.clk_en = 1'b0; bus.we = 1'b0; bus.addr = 16'h0000; bus.dataFromCore = 8'h00;
        bus.dataFromBram[BRAM_PROG_RAM] = 8'h11;
        bus.dataFromBram[BRAM_PROG_ROM] = 8'hA9;
        bus.dataFromBram[BRAM_VECTOR]   = 8'h22;
        bus.dataFromBram[BRAM_MATH]     = 8'h33;
        bus.dataFromBram[BRAM_POKEY]    = 8'h44;
        #2;
        test_reset();
        test_ram_write();
        test_bram_writes();
        test_strobes();
        test_in0_read();
        test_rom_read();
        test_region_reads();
        test_reset_pending();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
